vending_machine_multi: RTL

VENDING_MACHINE_MULTI -- requirements
Module: vending_machine_multi

---
 rtl/vending_pkg.sv | 16 +
 rtl/change_dispenser.sv | 32 +++
 rtl/vending_machine_multi.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared definitions for the multi-product vending machine: FSM encoding and
// coin values expressed in 5-cent units.
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CREDIT   = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_t;

  localparam int NICKEL_V  = 1;
  localparam int DIME_V    = 2;
  localparam int QUARTER_V = 5;

endpackage

// File: rtl/change_dispenser.sv
// Greedy coin picker: given the amount still owed, selects the single largest
// coin that fits and reports its value so the caller can decrement credit.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int CREDIT_W = 6
) (
  input  logic [CREDIT_W-1:0] remaining,
  output logic                ret_quarter,
  output logic                ret_dime,
  output logic                ret_nickel,
  output logic [CREDIT_W-1:0] dec
);

  always_comb begin
    ret_quarter = 1'b0;
    ret_dime    = 1'b0;
    ret_nickel  = 1'b0;
    dec         = '0;
    if (remaining >= CREDIT_W'(QUARTER_V)) begin
      ret_quarter = 1'b1;
      dec         = CREDIT_W'(QUARTER_V);
    end else if (remaining >= CREDIT_W'(DIME_V)) begin
      ret_dime = 1'b1;
      dec      = CREDIT_W'(DIME_V);
    end else if (remaining != '0) begin
      ret_nickel = 1'b1;
      dec        = CREDIT_W'(NICKEL_V);
    end
  end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending machine: accepts coins up to a ceiling, vends a priced
// product on request and returns any remainder one coin per cycle.
module vending_machine_multi
  import vending_pkg::*;
#(
  parameter int NUM_PRODUCTS = 4,
  parameter int CREDIT_W = 6,
  parameter int MAX_CREDIT = 40,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES = {6'd13, 6'd10, 6'd7, 6'd5},
  localparam int SEL_W = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                select,
  input  logic [SEL_W-1:0]    sel_id,
  input  logic                cancel,
  output logic                dispense,
  output logic [SEL_W-1:0]    dispense_id,
  output logic                returnQuarter,
  output logic                returnDime,
  output logic                returnNickel,
  output logic                coin_reject,
  output logic                sel_error,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  state_t              state;
  logic [SEL_W-1:0]    vend_id;
  logic [CREDIT_W-1:0] vend_price;

  logic [CREDIT_W-1:0] coin_v;
  logic                one_coin;
  logic                any_coin;
  logic [CREDIT_W:0]   credit_sum;
  logic                coin_ok;
  logic [CREDIT_W-1:0] price;
  logic                sel_valid;
  logic                can_vend;

  logic                chg_q;
  logic                chg_d;
  logic                chg_n;
  logic [CREDIT_W-1:0] chg_dec;

  // Exactly one coin line must be high for the coin to have a value.
  always_comb begin
    coin_v   = '0;
    one_coin = 1'b0;
    case ({quarter, dime, nickel})
      3'b001: begin coin_v = CREDIT_W'(NICKEL_V);  one_coin = 1'b1; end
      3'b010: begin coin_v = CREDIT_W'(DIME_V);    one_coin = 1'b1; end
      3'b100: begin coin_v = CREDIT_W'(QUARTER_V); one_coin = 1'b1; end
      default: begin coin_v = '0; one_coin = 1'b0; end
    endcase
  end

  assign any_coin   = nickel | dime | quarter;
  assign credit_sum = {1'b0, credit} + {1'b0, coin_v};
  assign coin_ok    = one_coin && (credit_sum <= (CREDIT_W+1)'(MAX_CREDIT));

  // Out-of-range indices simply never match, leaving sel_valid low.
  always_comb begin
    price     = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (int'(sel_id) == i) begin
        price     = PRICES[i*CREDIT_W +: CREDIT_W];
        sel_valid = 1'b1;
      end
    end
  end

  assign can_vend = sel_valid && (credit >= price);

  change_dispenser #(.CREDIT_W(CREDIT_W)) u_change (
    .remaining   (credit),
    .ret_quarter (chg_q),
    .ret_dime    (chg_d),
    .ret_nickel  (chg_n),
    .dec         (chg_dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      credit        <= '0;
      vend_id       <= '0;
      vend_price    <= '0;
      dispense      <= 1'b0;
      dispense_id   <= '0;
      returnQuarter <= 1'b0;
      returnDime    <= 1'b0;
      returnNickel  <= 1'b0;
      coin_reject   <= 1'b0;
      sel_error     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      dispense      <= 1'b0;
      dispense_id   <= '0;
      returnQuarter <= 1'b0;
      returnDime    <= 1'b0;
      returnNickel  <= 1'b0;
      coin_reject   <= 1'b0;
      sel_error     <= 1'b0;
      case (state)
        ST_IDLE, ST_CREDIT: begin
          if (cancel) begin
            // Cancel outranks coins and select; a coin offered alongside it is refused.
            coin_reject <= any_coin;
            if (state == ST_CREDIT) begin
              state <= ST_CHANGE;
              busy  <= 1'b1;
            end
          end else if (any_coin) begin
            if (coin_ok) begin
              credit <= credit_sum[CREDIT_W-1:0];
              state  <= ST_CREDIT;
            end else begin
              coin_reject <= 1'b1;
            end
          end else if (select && (state == ST_CREDIT)) begin
            if (can_vend) begin
              state      <= ST_DISPENSE;
              busy       <= 1'b1;
              vend_id    <= sel_id;
              vend_price <= price;
            end else begin
              sel_error <= 1'b1;
            end
          end
        end
        ST_DISPENSE: begin
          coin_reject <= any_coin;
          dispense    <= 1'b1;
          dispense_id <= vend_id;
          credit      <= credit - vend_price;
          if (credit == vend_price) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= ST_CHANGE;
          end
        end
        ST_CHANGE: begin
          coin_reject   <= any_coin;
          returnQuarter <= chg_q;
          returnDime    <= chg_d;
          returnNickel  <= chg_n;
          credit        <= credit - chg_dec;
          if (credit == chg_dec) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
